mul_arbiter: RTL and testbench

MUL_ARBITER -- requirements
Module: mul_arbiter

---
 rtl/mul_arbiter.sv | 139 +++++++++++++
 tb/tb_mul_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_arbiter.sv
// Two-requester round-robin front end for one shared 16x16 multiplier.
// One operation in flight; result registered on entry to DONE.
module mul_arbiter #(
    parameter int MUL_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [15:0] op_a0,
    input  logic [15:0] op_b0,
    input  logic [15:0] op_a1,
    input  logic [15:0] op_b1,
    input  logic [1:0]  sgn,
    output logic [1:0]  gnt,
    output logic [1:0]  rsp_vld,
    output logic [15:0] rsp_lo,
    output logic [15:0] rsp_hi,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    localparam logic [3:0] LAT = 4'(MUL_LAT);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ptr_q, ptr_d;
    logic        own_q, own_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic        sgn_q, sgn_d;
    logic [1:0]  vld_q, vld_d;
    logic [15:0] lo_q, lo_d;
    logic [15:0] hi_q, hi_d;

    logic [31:0] ext_a;
    logic [31:0] ext_b;
    logic [31:0] prod;

    // On a tie the requester that was not granted last wins.
    always_comb begin
        gnt = 2'b00;
        if (!rst && state_q != S_BUSY) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = ptr_q ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_comb begin
        ext_a = sgn_q ? {{16{a_q[15]}}, a_q} : {16'h0000, a_q};
        ext_b = sgn_q ? {{16{b_q[15]}}, b_q} : {16'h0000, b_q};
        prod  = ext_a * ext_b;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        own_d   = own_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        vld_d   = 2'b00;
        lo_d    = lo_q;
        hi_d    = hi_q;

        case (state_q)
            S_BUSY: begin
                if (cnt_q == LAT) begin
                    state_d = S_DONE;
                    cnt_d   = 4'd0;
                    vld_d   = own_q ? 2'b10 : 2'b01;
                    lo_d    = prod[15:0];
                    hi_d    = prod[31:16];
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A grant overrides the DONE->IDLE return for back-to-back work.
        if (gnt != 2'b00) begin
            state_d = S_BUSY;
            cnt_d   = 4'd1;
            own_d   = gnt[1];
            ptr_d   = gnt[1];
            a_d     = gnt[1] ? op_a1 : op_a0;
            b_d     = gnt[1] ? op_b1 : op_b0;
            sgn_d   = gnt[1] ? sgn[1] : sgn[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            ptr_q   <= 1'b1;
            own_q   <= 1'b0;
            a_q     <= 16'h0000;
            b_q     <= 16'h0000;
            sgn_q   <= 1'b0;
            vld_q   <= 2'b00;
            lo_q    <= 16'h0000;
            hi_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            vld_q   <= vld_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

    assign rsp_vld = vld_q;
    assign rsp_lo  = lo_q;
    assign rsp_hi  = hi_q;
    assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter with MUL_LAT=3.
// Inputs change 1 time unit after posedge; outputs checked 1 unit later.
module tb_mul_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [15:0] op_a0, op_b0, op_a1, op_b1;
    logic [1:0]  sgn;
    logic [1:0]  gnt;
    logic [1:0]  rsp_vld;
    logic [15:0] rsp_lo, rsp_hi;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    mul_arbiter #(.MUL_LAT(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .op_a0   (op_a0),
        .op_b0   (op_b0),
        .op_a1   (op_a1),
        .op_b1   (op_b1),
        .sgn     (sgn),
        .gnt     (gnt),
        .rsp_vld (rsp_vld),
        .rsp_lo  (rsp_lo),
        .rsp_hi  (rsp_hi),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; req = 2'b00; sgn = 2'b00;
        op_a0 = '0; op_b0 = '0; op_a1 = '0; op_b1 = '0;
        tick();
        // gnt must stay low during reset even with requests
        req = 2'b11;
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        tick();
        req = 2'b00;
        #1;
        chk("rst_vld", 32'(rsp_vld), 32'h0);
        chk("rst_lo", 32'(rsp_lo), 32'h0);
        chk("rst_hi", 32'(rsp_hi), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);

        // Unsigned single request
        tick();
        rst = 1'b0; req = 2'b01; op_a0 = 16'hFFFF; op_b0 = 16'hFFFF;
        #1;
        chk("u_gnt", 32'(gnt), 32'h1);
        chk("u_busy0", 32'(busy), 32'h0);
        tick(); req = 2'b00; #1;
        chk("u_busy1", 32'(busy), 32'h1);
        chk("u_vld1", 32'(rsp_vld), 32'h0);
        tick(); #1;
        chk("u_vld2", 32'(rsp_vld), 32'h0);
        tick(); #1;
        chk("u_vld3", 32'(rsp_vld), 32'h0);
        tick(); #1;
        chk("u_vld4", 32'(rsp_vld), 32'h1);
        chk("u_lo", 32'(rsp_lo), 32'h0001);
        chk("u_hi", 32'(rsp_hi), 32'hFFFE);
        chk("u_busy4", 32'(busy), 32'h1);
        tick(); #1;
        chk("u_vld5", 32'(rsp_vld), 32'h0);
        chk("u_busy5", 32'(busy), 32'h0);
        chk("u_hold_lo", 32'(rsp_lo), 32'h0001);

        // Signed requester 1, then same operands unsigned
        req = 2'b10; sgn = 2'b10; op_a1 = 16'h8000; op_b1 = 16'h7FFF;
        #1;
        chk("s_gnt", 32'(gnt), 32'h2);
        tick(); req = 2'b00;
        tick(); tick(); tick(); #1;
        chk("s_vld", 32'(rsp_vld), 32'h2);
        chk("s_lo", 32'(rsp_lo), 32'h8000);
        chk("s_hi", 32'(rsp_hi), 32'hC000);
        tick();
        req = 2'b10; sgn = 2'b00;
        #1;
        chk("su_gnt", 32'(gnt), 32'h2);
        tick(); req = 2'b00;
        tick(); tick(); tick(); #1;
        chk("su_vld", 32'(rsp_vld), 32'h2);
        chk("su_lo", 32'(rsp_lo), 32'h8000);
        chk("su_hi", 32'(rsp_hi), 32'h3FFF);

        // Contention from reset release
        tick(); rst = 1'b1; tick(); rst = 1'b0;
        op_a0 = 16'd2; op_b0 = 16'd3; op_a1 = 16'd5; op_b1 = 16'd7;
        for (int k = 0; k < 5; k++) begin
            req = (k < 4) ? 2'b11 : 2'b00;
            #1;
            chk("c_gnt", 32'(gnt),
                (k == 4) ? 32'h0 : ((k % 2 == 0) ? 32'h1 : 32'h2));
            if (k > 0) begin
                chk("c_vld", 32'(rsp_vld),
                    ((k - 1) % 2 == 0) ? 32'h1 : 32'h2);
                chk("c_lo", 32'(rsp_lo),
                    ((k - 1) % 2 == 0) ? 32'd6 : 32'd35);
            end
            if (k < 4) begin
                for (int j = 0; j < 3; j++) begin
                    tick(); #1;
                    chk("c_busy_gnt", 32'(gnt), 32'h0);
                    chk("c_busy", 32'(busy), 32'h1);
                end
            end
            tick();
        end
        #1;
        chk("c_idle", 32'(busy), 32'h0);

        // Back-to-back single requester
        req = 2'b01; op_a0 = 16'h0100; op_b0 = 16'h0100;
        #1;
        chk("b_gnt0", 32'(gnt), 32'h1);
        for (int k = 1; k < 3; k++) begin
            for (int j = 0; j < 3; j++) begin
                tick(); #1;
                chk("b_busy", 32'(busy), 32'h1);
            end
            tick(); #1;
            chk("b_gnt", 32'(gnt), 32'h1);
            chk("b_vld", 32'(rsp_vld), 32'h1);
            chk("b_hi", 32'(rsp_hi), 32'h0001);
            chk("b_lo", 32'(rsp_lo), 32'h0000);
            chk("b_busyd", 32'(busy), 32'h1);
        end
        tick(); req = 2'b00;
        tick(); tick(); tick(); #1;
        chk("b_last_vld", 32'(rsp_vld), 32'h1);
        tick();

        // Reset in the second BUSY cycle
        req = 2'b01; sgn = 2'b01; op_a0 = 16'hFFFE; op_b0 = 16'h0010;
        #1;
        chk("r_gnt", 32'(gnt), 32'h1);
        tick(); req = 2'b00;
        tick(); rst = 1'b1;
        tick(); rst = 1'b0; req = 2'b11;
        #1;
        chk("r_busy", 32'(busy), 32'h0);
        chk("r_vld", 32'(rsp_vld), 32'h0);
        chk("r_lo", 32'(rsp_lo), 32'h0);
        chk("r_hi", 32'(rsp_hi), 32'h0);
        chk("r_gnt_after", 32'(gnt), 32'h1);
        for (int j = 0; j < 3; j++) begin
            tick(); #1;
            chk("r_novld", 32'(rsp_vld), 32'h0);
        end
        tick(); #1;
        chk("r_vld0", 32'(rsp_vld), 32'h1);
        chk("r_lo0", 32'(rsp_lo), 32'hFFE0);
        chk("r_hi0", 32'(rsp_hi), 32'hFFFF);
        chk("r_gnt1", 32'(gnt), 32'h2);
        tick(); req = 2'b00;
        tick(); tick(); tick(); #1;
        chk("r_vld1", 32'(rsp_vld), 32'h2);
        chk("r_lo1", 32'(rsp_lo), 32'd35);
        tick();

        // Request withdrawn after grant
        req = 2'b01; sgn = 2'b00; op_a0 = 16'h0003; op_b0 = 16'hFFFF;
        #1;
        chk("w_gnt", 32'(gnt), 32'h1);
        tick(); req = 2'b00; op_a0 = 16'hDEAD; op_b0 = 16'hBEEF;
        tick(); tick(); tick(); #1;
        chk("w_vld", 32'(rsp_vld), 32'h1);
        chk("w_lo", 32'(rsp_lo), 32'hFFFD);
        chk("w_hi", 32'(rsp_hi), 32'h0002);
        tick(); #1;
        chk("w_idle", 32'(busy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
